alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Owns the alarm behaviour of the digital clock. Compares BCD wall time against the stored BCD alarm time and sequences the alarm through armed, ringing and snooze states.
- Generates the buzzer square wave, enforces a ring timeout and limits the number of snoozes.
- Sits between the clock/alarm counter block (time and alarm digits, 1 Hz tick) and the buzzer pin. Exports status for the VGA overlay.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TONE_HZ, 2000, buzzer square-wave frequency in Hz. HALF = CLK_HZ/(2*TONE_HZ), must be ≥1.
- RING_SEC, 60, seconds of ringing before auto-stop.
- SNOOZE_SEC, 300, snooze length in seconds.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tick_1Hz  in  1  one-cycle pulse once per second, synchronous to clk_100MHz.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  current time, BCD.
- alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  in  4 each  alarm time, BCD.
- alarm_en  in  1  alarm enable switch (level).
- set_alarm  in  1  alarm-edit mode (level); blocks new triggers.
- snooze  in  1  one-cycle pulse, already debounced.
- dismiss  in  1  one-cycle pulse, already debounced.
- buzzer  out  1  square wave while ringing, else 0.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snooze_left  out  2  snoozes remaining, saturates at 3.
- state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.

Behaviour:
- Reset (async assert, sync release): state=IDLE, buzzer=0, ringing=0, snoozing=0, snooze_left=MAX_SNOOZE, all counters 0, match_d=0.
- match (combinational) = all four hr/min digit pairs equal AND sec_10s==0 AND sec_1s==0. match_d is match registered each cycle.
- trig = match & ~match_d & ~set_alarm. It fires once per matching minute.
- Setting the time into the alarm minute with seconds ≠ 00 does not trigger.
- IDLE:
  - alarm_en=1 → ARMED next cycle.
- ARMED:
  - alarm_en=0 → IDLE.
  - trig → RINGING; ring_cnt=0, snooze_left=MAX_SNOOZE, tone counter=0, buzzer starts at 0.
- RINGING:
  - Each tick_1Hz increments ring_cnt. The tick that makes ring_cnt==RING_SEC → ARMED (timeout).
  - snooze with snooze_left>0 → SNOOZE; snz_cnt=SNOOZE_SEC, snooze_left decrements.
  - snooze with snooze_left==0 → ARMED (treated as dismiss).
  - dismiss → ARMED.
- SNOOZE:
  - Each tick_1Hz decrements snz_cnt. The tick that makes snz_cnt==0 → RINGING with ring_cnt=0; snooze_left is kept.
  - dismiss → ARMED. snooze is ignored.
- Priority in any single cycle: alarm_en=0 (→IDLE from any state) > dismiss > snooze > tick_1Hz timeout/expiry > trig.
  - Example: snooze and the timeout tick in the same cycle → SNOOZE.
- trig while in RINGING or SNOOZE is ignored.
- Tone generation:
  - In RINGING, a counter runs 0..HALF-1 and buzzer toggles on wrap, giving period 2*HALF cycles.
  - Outside RINGING the counter is held at 0 and buzzer is forced to 0 on the cycle the state leaves RINGING (registered, 1-cycle latency).
- ringing, snoozing and state are registered decodes of the state register, valid the cycle after the transition.
- Counter widths:
  - ring_cnt is sized by $clog2(RING_SEC+1).
  - snz_cnt is sized by $clog2(SNOOZE_SEC+1).
  - No wrap is possible, because each counter exits its state at its bound.
- Leaving IDLE resets no alarm digits. This block never writes time or alarm values.

Test Plan:
- All cases use CLK_HZ=1000, TONE_HZ=100 (HALF=5), RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, with tick_1Hz driven as a pulse every 20 cycles.
- Reset/arm: reset_n low mid-RINGING → next edge state=0, buzzer=0, snooze_left=2. Then release with alarm_en=1 → state=1 one cycle later.
- Trigger/tone: alarm 07:30; time steps 07:29:59→07:30:00 → state=2. Buzzer toggles every 5 cycles. Holding 07:30:00 for 100 cycles gives no retrigger.
- Edit and mid-minute: time jumps to 07:30:17 → no trigger. Time reaches 07:30:00 with set_alarm=1 → no trigger, state stays 1.
- Timeout/priority: ringing, 5 ticks → state=1, buzzer=0. In a repeat run, snooze and the 5th tick in the same cycle → state=3.
- Snooze limit: snooze → 3 ticks → ringing → snooze → 3 ticks → ringing (snooze_left=0) → snooze → state=1. Dismiss and snooze together in RINGING → state=1.
- Enable drop: alarm_en=0 during SNOOZE → state=0. Re-enable → state=1, no ring until the next 00-second match.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm behaviour of the digital clock.
//
// Compares the BCD wall time against the stored BCD alarm time and steps the
// alarm through IDLE, ARMED, RINGING and SNOOZE. While ringing it drives a
// square wave on the buzzer pin. A ring times out after RING_SEC seconds.
// A snooze lasts SNOOZE_SEC seconds. At most MAX_SNOOZE snoozes are allowed
// per alarm event.
//
// Ports:
//   clk_100MHz            system clock
//   reset_n               asynchronous active-low reset, released synchronously upstream
//   tick_1Hz              one-cycle pulse once per second
//   hr_10s .. sec_1s      current time, BCD digits
//   alarm_hr_10s ..       alarm time (hours/minutes), BCD digits
//   alarm_en              alarm enable switch (level)
//   set_alarm             alarm-edit mode (level); suppresses new triggers
//   snooze, dismiss       one-cycle debounced button pulses
//   buzzer                square wave while ringing, else 0
//   ringing, snoozing     registered state decodes for the overlay
//   snooze_left           snoozes remaining in the current alarm event
//   state                 IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
module alarm_sequencer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TONE_HZ    = 2000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       tick_1Hz,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  input  logic [3:0] alarm_hr_10s,
  input  logic [3:0] alarm_hr_1s,
  input  logic [3:0] alarm_min_10s,
  input  logic [3:0] alarm_min_1s,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_left,
  output logic [1:0] state
);

  localparam int unsigned HALF    = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned ToneW   = ($clog2(HALF) > 0) ? $clog2(HALF) : 1;
  localparam int unsigned RingW   = ($clog2(RING_SEC + 1) > 0) ? $clog2(RING_SEC + 1) : 1;
  localparam int unsigned SnzW    = ($clog2(SNOOZE_SEC + 1) > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
  // The snooze_left port is two bits wide, so the reload value saturates at 3.
  localparam logic [1:0]  SnzMax  = (MAX_SNOOZE > 3) ? 2'd3 : 2'(MAX_SNOOZE);

  localparam logic [ToneW-1:0] ToneMax = ToneW'(HALF - 1);
  localparam logic [RingW-1:0] RingMax = RingW'(RING_SEC);
  localparam logic [SnzW-1:0]  SnzInit = SnzW'(SNOOZE_SEC);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRinging = 2'd2,
    StSnooze  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
  logic [1:0]       snooze_left_q, snooze_left_d;
  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             match, match_q, trig;
  logic             ringing_q, snoozing_q;
  logic [1:0]       state_out_q;

  // Trigger only at the first cycle of the 00-second of the alarm minute, so a
  // time jump into the middle of the minute or a held time never (re)triggers.
  assign match = (hr_10s == alarm_hr_10s) && (hr_1s == alarm_hr_1s) &&
                 (min_10s == alarm_min_10s) && (min_1s == alarm_min_1s) &&
                 (sec_10s == 4'd0) && (sec_1s == 4'd0);
  assign trig  = match & ~match_q & ~set_alarm;

  // Next state. Priority: enable drop > dismiss > snooze > tick expiry > trig.
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    snooze_left_d = snooze_left_q;

    if (!alarm_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArmed;
        end
        StArmed: begin
          if (trig) begin
            state_d       = StRinging;
            ring_cnt_d    = '0;
            snooze_left_d = SnzMax;
          end
        end
        StRinging: begin
          if (dismiss) begin
            state_d = StArmed;
          end else if (snooze) begin
            if (snooze_left_q != 2'd0) begin
              state_d       = StSnooze;
              snz_cnt_d     = SnzInit;
              snooze_left_d = snooze_left_q - 2'd1;
            end else begin
              // Out of snoozes: the button acts as dismiss.
              state_d = StArmed;
            end
          end else if (tick_1Hz) begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            if (ring_cnt_d == RingMax) begin
              state_d = StArmed;
            end
          end
        end
        StSnooze: begin
          if (dismiss) begin
            state_d = StArmed;
          end else if (tick_1Hz) begin
            snz_cnt_d = snz_cnt_q - 1'b1;
            if (snz_cnt_d == '0) begin
              state_d    = StRinging;
              ring_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Tone: runs only while staying in RINGING, so every entry starts with the
  // buzzer low and a fresh half period, and any exit clears it at that edge.
  always_comb begin
    tone_cnt_d = '0;
    buzzer_d   = 1'b0;
    if ((state_q == StRinging) && (state_d == StRinging)) begin
      if (tone_cnt_q == ToneMax) begin
        tone_cnt_d = '0;
        buzzer_d   = ~buzzer_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        buzzer_d   = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      snooze_left_q <= SnzMax;
      tone_cnt_q    <= '0;
      buzzer_q      <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snooze_left_q <= snooze_left_d;
      tone_cnt_q    <= tone_cnt_d;
      buzzer_q      <= buzzer_d;
      match_q       <= match;
    end
  end

  // Status decodes registered from the next state so they line up with state_q.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ringing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
      state_out_q <= 2'd0;
    end else begin
      ringing_q   <= (state_d == StRinging);
      snoozing_q  <= (state_d == StSnooze);
      state_out_q <= state_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;
  assign state       = state_out_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned TONE_HZ    = 100;
  localparam int unsigned RING_SEC   = 5;
  localparam int unsigned SNOOZE_SEC = 3;
  localparam int unsigned MAX_SNOOZE = 2;
  localparam int          HALF       = 5;
  localparam int          TICK_DIV   = 20;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic       tick_1Hz;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
  logic [3:0] alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s;
  logic       alarm_en, set_alarm, snooze, dismiss;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_left, state;

  // Time kept as plain integers; BCD digits derived from them.
  int t_h, t_m, t_s, a_h, a_m;
  assign hr_10s        = 4'(t_h / 10);
  assign hr_1s         = 4'(t_h % 10);
  assign min_10s       = 4'(t_m / 10);
  assign min_1s        = 4'(t_m % 10);
  assign sec_10s       = 4'(t_s / 10);
  assign sec_1s        = 4'(t_s % 10);
  assign alarm_hr_10s  = 4'(a_h / 10);
  assign alarm_hr_1s   = 4'(a_h % 10);
  assign alarm_min_10s = 4'(a_m / 10);
  assign alarm_min_1s  = 4'(a_m % 10);

  alarm_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .TONE_HZ   (TONE_HZ),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .tick_1Hz     (tick_1Hz),
    .hr_10s       (hr_10s),
    .hr_1s        (hr_1s),
    .min_10s      (min_10s),
    .min_1s       (min_1s),
    .sec_10s      (sec_10s),
    .sec_1s       (sec_1s),
    .alarm_hr_10s (alarm_hr_10s),
    .alarm_hr_1s  (alarm_hr_1s),
    .alarm_min_10s(alarm_min_10s),
    .alarm_min_1s (alarm_min_1s),
    .alarm_en     (alarm_en),
    .set_alarm    (set_alarm),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left),
    .state        (state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;
  int tick_div = 0;

  // Reference model: 0 idle, 1 armed, 2 ringing, 3 snooze.
  int m_state, m_ring_s, m_snz_s, m_left, m_ring_cyc;
  bit m_prev;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_ring_s   = 0;
    m_snz_s    = 0;
    m_left     = MAX_SNOOZE;
    m_ring_cyc = 0;
    m_prev     = 1'b0;
  endtask

  task automatic model_edge();
    int nxt;
    bit match, trig;
    if (!reset_n) begin
      model_reset();
      return;
    end
    match  = (t_h == a_h) && (t_m == a_m) && (t_s == 0);
    trig   = match && !m_prev && !set_alarm;
    m_prev = match;
    nxt    = m_state;
    if (!alarm_en) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (trig) begin
        nxt = 2; m_ring_s = 0; m_left = MAX_SNOOZE;
      end
    end else if (m_state == 2) begin
      if (dismiss) nxt = 1;
      else if (snooze) begin
        if (m_left > 0) begin
          nxt = 3; m_snz_s = SNOOZE_SEC; m_left--;
        end else nxt = 1;
      end else if (tick_1Hz) begin
        m_ring_s++;
        if (m_ring_s == RING_SEC) nxt = 1;
      end
    end else begin
      if (dismiss) nxt = 1;
      else if (tick_1Hz) begin
        m_snz_s--;
        if (m_snz_s == 0) begin
          nxt = 2; m_ring_s = 0;
        end
      end
    end
    if (m_state == 2 && nxt == 2) m_ring_cyc++;
    else m_ring_cyc = 0;
    m_state = nxt;
  endtask

  task automatic compare_all();
    int exp_buz;
    exp_buz = (m_state == 2) ? ((m_ring_cyc / HALF) % 2) : 0;
    check("state", int'(state), m_state);
    check("ringing", int'(ringing), int'(m_state == 2));
    check("snoozing", int'(snoozing), int'(m_state == 3));
    check("snooze_left", int'(snooze_left), m_left);
    check("buzzer", int'(buzzer), exp_buz);
  endtask

  // One clock: inputs already set; pulses cleared afterwards.
  task automatic step();
    tick_1Hz = (tick_div == TICK_DIV - 1);
    @(posedge clk_100MHz);
    model_edge();
    tick_div = (tick_div + 1) % TICK_DIV;
    #1;
    compare_all();
    snooze  = 1'b0;
    dismiss = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    int guard = 0;
    while (c < n && guard < 1000) begin
      if (tick_div == TICK_DIV - 1) c++;
      step();
      guard++;
    end
    check("tick_budget", int'(c == n), 1);
  endtask

  task automatic snooze_on_tick();
    int guard = 0;
    while (tick_div != TICK_DIV - 1 && guard < TICK_DIV) begin
      step();
      guard++;
    end
    snooze = 1'b1;
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = h; t_m = m; t_s = s;
  endtask

  task automatic retrigger();
    set_time(7, 31, 0);
    step();
    set_time(7, 30, 0);
    step();
    check("retrigger_ring", int'(state), 2);
  endtask

  initial begin
    reset_n   = 1'b0;
    tick_1Hz  = 1'b0;
    alarm_en  = 1'b0;
    set_alarm = 1'b0;
    snooze    = 1'b0;
    dismiss   = 1'b0;
    a_h = 7; a_m = 30;
    set_time(7, 29, 50);
    model_reset();

    // Reset values and arming.
    repeat (3) @(posedge clk_100MHz);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_buzzer", int'(buzzer), 0);
    check("rst_left", int'(snooze_left), MAX_SNOOZE);
    check("rst_ringing", int'(ringing), 0);
    check("rst_snoozing", int'(snoozing), 0);
    reset_n  = 1'b1;
    alarm_en = 1'b1;
    step();
    check("arm", int'(state), 1);

    // Trigger, tone, no retrigger while held at 07:30:00.
    set_time(7, 29, 59);
    steps(3);
    set_time(7, 30, 0);
    step();
    check("trigger", int'(state), 2);
    steps(140);
    check("timeout_armed", int'(state), 1);
    check("timeout_buzzer", int'(buzzer), 0);

    // Mid-minute jump and edit mode do not trigger.
    set_time(7, 31, 0);
    step();
    set_time(7, 30, 17);
    steps(5);
    check("mid_minute", int'(state), 1);
    set_alarm = 1'b1;
    set_time(7, 29, 59);
    step();
    set_time(7, 30, 0);
    steps(3);
    check("edit_block", int'(state), 1);
    set_alarm = 1'b0;
    steps(3);
    check("edit_release", int'(state), 1);

    // Snooze on the same cycle as the timeout tick wins.
    retrigger();
    wait_ticks(4);
    snooze_on_tick();
    check("snooze_vs_timeout", int'(state), 3);
    check("left_after_snz1", int'(snooze_left), 1);

    // Snooze limit.
    wait_ticks(3);
    check("snz_expire1", int'(state), 2);
    check("left_kept", int'(snooze_left), 1);
    snooze = 1'b1;
    step();
    check("snz2", int'(state), 3);
    wait_ticks(3);
    check("snz_expire2", int'(state), 2);
    check("left_zero", int'(snooze_left), 0);
    snooze = 1'b1;
    step();
    check("snooze_as_dismiss", int'(state), 1);

    // Dismiss beats snooze.
    retrigger();
    snooze  = 1'b1;
    dismiss = 1'b1;
    step();
    check("dismiss_prio", int'(state), 1);

    // Enable drop during snooze, re-enable without ringing.
    retrigger();
    snooze = 1'b1;
    step();
    check("enter_snooze", int'(state), 3);
    alarm_en = 1'b0;
    step();
    check("en_drop", int'(state), 0);
    alarm_en = 1'b1;
    step();
    check("re_enable", int'(state), 1);
    steps(60);
    check("no_ring_after_en", int'(state), 1);

    // Reset mid-ringing after a snooze.
    retrigger();
    snooze = 1'b1;
    step();
    wait_ticks(3);
    steps(7);
    check("pre_reset_buzzer", int'(buzzer), 1);
    reset_n = 1'b0;
    step();
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_buzzer", int'(buzzer), 0);
    check("mid_rst_left", int'(snooze_left), MAX_SNOOZE);
    reset_n = 1'b1;
    step();
    check("post_rst_arm", int'(state), 1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 149) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 49) == 0) set_alarm = ~set_alarm;
      snooze  = ($urandom_range(0, 24) == 0);
      dismiss = ($urandom_range(0, 59) == 0);
      r = int'($urandom_range(0, 39));
      case (r)
        0: set_time(7, 29, 59);
        1: set_time(7, 30, 0);
        2: set_time(7, 30, int'($urandom_range(1, 59)));
        3: set_time(7, 31, 0);
        4: set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 0);
        default: ;
      endcase
      reset_n = ($urandom_range(0, 499) != 0);
      step();
      reset_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
